// File: rtl/qlearn_pkg.sv
// Shared Q-learning constants, Q-table address helper and reader FSM type.
// Imported by the update pipeline, table and greedy reader modules.
package qlearn_pkg;

  localparam int STATE_WIDTH  = 6;
  localparam int ACTION_WIDTH = 2;
  localparam int NUM_ACTIONS  = 1 << ACTION_WIDTH;
  localparam int ADDR_WIDTH   = STATE_WIDTH + ACTION_WIDTH;
  localparam int DATA_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_RESP
  } rd_state_e;

  function automatic logic [ADDR_WIDTH-1:0] q_addr(
    input logic [STATE_WIDTH-1:0]  s,
    input logic [ACTION_WIDTH-1:0] a
  );
    return {s, a};
  endfunction

endpackage

// File: rtl/argmax_accum.sv
// Running argmax over returned Q entries: action 0 loads, later ones win only if strictly greater.
// Ports: i_clk, i_rst_n, i_clear, i_vld, i_action, i_q -> o_best_a, o_best_q.
module argmax_accum
  import qlearn_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_vld,
  input  logic [ACTION_WIDTH-1:0] i_action,
  input  logic [DATA_WIDTH-1:0]   i_q,
  output logic [ACTION_WIDTH-1:0] o_best_a,
  output logic [DATA_WIDTH-1:0]   o_best_q
);

  logic [ACTION_WIDTH-1:0] r_best_a;
  logic [DATA_WIDTH-1:0]   r_best_q;
  logic                    w_take;

  // strict compare keeps the lowest index on ties
  assign w_take = i_vld &&
    ((i_action == '0) || (i_q > r_best_q));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_best_a <= '0;
      r_best_q <= '0;
    end else if (i_clear) begin
      r_best_a <= '0;
      r_best_q <= '0;
    end else if (w_take) begin
      r_best_a <= i_action;
      r_best_q <= i_q;
    end
  end

  assign o_best_a = r_best_a;
  assign o_best_q = r_best_q;

endmodule

// File: rtl/qtable_greedy_reader.sv
// Greedy Q-table reader: scans all actions of a state, returns argmax action and its Q.
// Ports: req (valid/ready/state), rsp (valid/ready/action/qmax), Q-table read port with busy stall.
module qtable_greedy_reader
  import qlearn_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [STATE_WIDTH-1:0]  i_req_state,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [ACTION_WIDTH-1:0] o_rsp_action,
  output logic [DATA_WIDTH-1:0]   o_rsp_qmax,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_rd_en,
  input  logic [DATA_WIDTH-1:0]   i_mem_data,
  input  logic                    i_mem_busy
);

  localparam logic [ACTION_WIDTH-1:0] LAST_A =
    ACTION_WIDTH'(NUM_ACTIONS - 1);

  rd_state_e               r_state;
  rd_state_e               w_next;
  logic [STATE_WIDTH-1:0]  r_sreg;
  logic [ACTION_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_rd_vld;
  logic [ACTION_WIDTH-1:0] r_rd_tag;

  logic w_accept;
  logic w_issue;
  logic w_last_issue;
  logic w_last_ret;
  logic w_rsp_hs;

  assign w_accept     = i_req_valid && (r_state == ST_IDLE);
  assign w_issue      = (r_state == ST_SCAN) && !i_mem_busy;
  assign w_last_issue = w_issue && (r_cnt == LAST_A);
  assign w_last_ret   = r_rd_vld && (r_rd_tag == LAST_A);
  assign w_rsp_hs     = (r_state == ST_RESP) && i_rsp_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept)     w_next = ST_SCAN;
      ST_SCAN:  if (w_last_issue) w_next = ST_DRAIN;
      ST_DRAIN: if (w_last_ret)   w_next = ST_RESP;
      ST_RESP:  if (w_rsp_hs)     w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (r_state == ST_IDLE);
    o_rsp_valid = (r_state == ST_RESP);
    o_mem_rd_en = w_issue;
    o_mem_addr  = w_issue ? q_addr(r_sreg, r_cnt) : r_addr;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sreg <= '0;
      r_cnt  <= '0;
      r_addr <= '0;
    end else begin
      if (w_accept) begin
        r_sreg <= i_req_state;
        r_cnt  <= '0;
      end else if (w_issue) begin
        r_cnt  <= r_cnt + 1'b1;
        r_addr <= q_addr(r_sreg, r_cnt);
      end
    end
  end

  // data returns one cycle after the strobe; tag it with its action
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_vld <= 1'b0;
      r_rd_tag <= '0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) r_rd_tag <= r_cnt;
    end
  end

  argmax_accum u_acc (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_accept),
    .i_vld    (r_rd_vld),
    .i_action (r_rd_tag),
    .i_q      (i_mem_data),
    .o_best_a (o_rsp_action),
    .o_best_q (o_rsp_qmax)
  );

endmodule

// File: tb/tb_qtable_greedy_reader.sv
// Self-checking bench for qtable_greedy_reader.
// Q-table memory model answers reads one cycle later; argmax reference is behavioural.
module tb_qtable_greedy_reader;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [5:0] i_req_state;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic [1:0] o_rsp_action;
  logic [7:0] o_rsp_qmax;
  logic [7:0] o_mem_addr;
  logic       o_mem_rd_en;
  logic [7:0] i_mem_data;
  logic       i_mem_busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  logic [7:0] addr_log [16];

  qtable_greedy_reader dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_state  (i_req_state),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_action (o_rsp_action),
    .o_rsp_qmax   (o_rsp_qmax),
    .o_mem_addr   (o_mem_addr),
    .o_mem_rd_en  (o_mem_rd_en),
    .i_mem_data   (i_mem_data),
    .i_mem_busy   (i_mem_busy)
  );

  always #5 i_clk = ~i_clk;

  // memory responder: data valid the cycle after a strobe, junk otherwise
  always @(posedge i_clk) begin
    if (o_mem_rd_en) i_mem_data <= mem[o_mem_addr];
    else             i_mem_data <= 8'($urandom);
  end

  function automatic void ref_argmax(
    input logic [5:0] s, output logic [1:0] a, output logic [7:0] q
  );
    a = 2'd0;
    q = mem[{s, 2'd0}];
    for (int i = 1; i < 4; i++)
      if (mem[{s, 2'(i)}] > q) begin
        a = 2'(i);
        q = mem[{s, 2'(i)}];
      end
  endfunction

  // cycles from acceptance edge to first edge seeing o_rsp_valid
  function automatic int exp_lat(input logic [31:0] m);
    int r = 0;
    int k = 0;
    while (r < 4) begin
      if (k >= 32 || !m[k]) r++;
      k++;
    end
    return k + 2;
  endfunction

  task automatic do_query(
    input  logic [5:0]  s,
    input  logic [31:0] busy_mask,
    input  int          ready_wait,
    input  bit          hold_req,
    input  logic [5:0]  s2,
    output bit          ok,
    output int          lat,
    output logic [1:0]  act,
    output logic [7:0]  q,
    output int          nrd,
    output int          busy_viol,
    output int          unstable,
    output int          rdy_viol
  );
    bit seen;
    bit acc;
    ok = 0; lat = 0; act = 0; q = 0;
    nrd = 0; busy_viol = 0; unstable = 0; rdy_viol = 0;
    @(posedge i_clk); #1;
    i_req_valid = 1'b1;
    i_req_state = s;
    acc = 0;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge i_clk);
      if (o_req_ready) acc = 1;
      else begin @(posedge i_clk); #1; end
    end
    if (!acc) begin i_req_valid = 1'b0; return; end
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_req_state = 6'($urandom);
    seen = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      i_mem_busy = (k < 32) ? busy_mask[k] : 1'b0;
      @(negedge i_clk);
      if (o_mem_rd_en) begin
        if (i_mem_busy) busy_viol++;
        if (nrd < 16) addr_log[nrd] = o_mem_addr;
        nrd++;
      end
      if (o_rsp_valid) begin
        seen = 1;
        lat = k + 1;
        act = o_rsp_action;
        q = o_rsp_qmax;
      end else begin
        @(posedge i_clk); #1;
      end
    end
    i_mem_busy = 1'b0;
    if (!seen) return;
    for (int w = 0; w <= ready_wait; w++) begin
      @(posedge i_clk); #1;
      if (hold_req) begin
        i_req_valid = 1'b1;
        i_req_state = s2;
      end
      if (w == ready_wait) i_rsp_ready = 1'b1;
      @(negedge i_clk);
      if (o_rsp_valid !== 1'b1 || o_rsp_action !== act ||
          o_rsp_qmax !== q) unstable++;
      if (hold_req && o_req_ready) rdy_viol++;
    end
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    ok = 1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_req_valid = 1'b0;
    i_req_state = '0;
    i_rsp_ready = 1'b0;
    i_mem_busy = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 ||
        o_mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b valid=%b rd_en=%b want 1 0 0",
               o_req_ready, o_rsp_valid, o_mem_rd_en);
    end
    checks++;
    if (o_rsp_action !== 2'd0 || o_rsp_qmax !== 8'd0 ||
        o_mem_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: act=%0d q=%h addr=%h want 0 00 00",
               o_rsp_action, o_rsp_qmax, o_mem_addr);
    end
  endtask

  task automatic test_basic();
    bit ok; int lat, nrd, bv, us, rv;
    logic [1:0] a; logic [7:0] q;
    mem[8'h14] = 8'h10; mem[8'h15] = 8'h30;
    mem[8'h16] = 8'h20; mem[8'h17] = 8'h05;
    do_query(6'd5, 32'd0, 0, 0, 6'd0, ok, lat, a, q, nrd, bv, us, rv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: ok=%0d want 1", ok);
    end
    checks++;
    if (nrd !== 4 || addr_log[0] !== 8'h14 || addr_log[1] !== 8'h15 ||
        addr_log[2] !== 8'h16 || addr_log[3] !== 8'h17) begin
      errors++;
      $display("FAIL basic_addr: n=%0d %h %h %h %h want 4 14 15 16 17",
               nrd, addr_log[0], addr_log[1], addr_log[2], addr_log[3]);
    end
    checks++;
    if (a !== 2'd1 || q !== 8'h30) begin
      errors++;
      $display("FAIL basic_result: act=%0d q=%h want 1 30", a, q);
    end
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL basic_latency: got T+%0d want T+6", lat);
    end
    @(negedge i_clk);
    checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_after_hs: valid=%b ready=%b want 0 1",
               o_rsp_valid, o_req_ready);
    end
  endtask

  task automatic test_ties();
    bit ok; int lat, nrd, bv, us, rv;
    logic [1:0] a; logic [7:0] q;
    for (int i = 0; i < 4; i++) mem[{6'd63, 2'(i)}] = 8'h40;
    do_query(6'd63, 32'd0, 0, 0, 6'd0, ok, lat, a, q, nrd, bv, us, rv);
    checks++;
    if (!ok || a !== 2'd0 || q !== 8'h40) begin
      errors++;
      $display("FAIL ties: ok=%0d act=%0d q=%h want 1 0 40", ok, a, q);
    end
    mem[8'hFC] = 8'h00; mem[8'hFD] = 8'h00;
    mem[8'hFE] = 8'h00; mem[8'hFF] = 8'hFF;
    do_query(6'd63, 32'd0, 0, 0, 6'd0, ok, lat, a, q, nrd, bv, us, rv);
    checks++;
    if (!ok || a !== 2'd3 || q !== 8'hFF) begin
      errors++;
      $display("FAIL top_unsigned: ok=%0d act=%0d q=%h want 1 3 ff",
               ok, a, q);
    end
    checks++;
    if (nrd !== 4 || addr_log[3] !== 8'hFF) begin
      errors++;
      $display("FAIL top_addr: n=%0d last=%h want 4 ff", nrd, addr_log[3]);
    end
  endtask

  task automatic test_busy();
    bit ok; int lat, nrd, bv, us, rv;
    logic [1:0] a; logic [7:0] q;
    do_query(6'd5, 32'h1C, 0, 0, 6'd0, ok, lat, a, q, nrd, bv, us, rv);
    checks++;
    if (!ok || a !== 2'd1 || q !== 8'h30) begin
      errors++;
      $display("FAIL busy_result: ok=%0d act=%0d q=%h want 1 1 30",
               ok, a, q);
    end
    checks++;
    if (bv !== 0 || nrd !== 4) begin
      errors++;
      $display("FAIL busy_reads: rd_while_busy=%0d n=%0d want 0 4", bv, nrd);
    end
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL busy_latency: got T+%0d want T+9", lat);
    end
  endtask

  task automatic test_backpressure();
    bit ok; bit seen; int lat, nrd, bv, us, rv;
    logic [1:0] a, ea; logic [7:0] q, eq;
    do_query(6'd5, 32'd0, 5, 1, 6'd63, ok, lat, a, q, nrd, bv, us, rv);
    checks++;
    if (!ok || us !== 0 || a !== 2'd1 || q !== 8'h30) begin
      errors++;
      $display("FAIL bp_stable: ok=%0d unstable=%0d act=%0d q=%h want 1 0 1 30",
               ok, us, a, q);
    end
    checks++;
    if (rv !== 0) begin
      errors++;
      $display("FAIL bp_req_ready: ready_high_in_resp=%0d want 0", rv);
    end
    @(negedge i_clk);
    checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle: valid=%b ready=%b want 0 1",
               o_rsp_valid, o_req_ready);
    end
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_req_ready !== 1'b0 || o_mem_rd_en !== 1'b1 ||
        o_mem_addr !== 8'hFC) begin
      errors++;
      $display("FAIL b2b_accept: ready=%b rd_en=%b addr=%h want 0 1 fc",
               o_req_ready, o_mem_rd_en, o_mem_addr);
    end
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge i_clk);
      if (o_rsp_valid) seen = 1;
    end
    ref_argmax(6'd63, ea, eq);
    checks++;
    if (!seen || o_rsp_action !== ea || o_rsp_qmax !== eq) begin
      errors++;
      $display("FAIL b2b_result: seen=%0d act=%0d q=%h want 1 %0d %h",
               seen, o_rsp_action, o_rsp_qmax, ea, eq);
    end
    @(posedge i_clk); #1 i_rsp_ready = 1'b1;
    @(posedge i_clk); #1 i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok; bit acc; int lat, nrd, bv, us, rv, stray;
    logic [1:0] a; logic [7:0] q;
    @(posedge i_clk); #1;
    i_req_valid = 1'b1;
    i_req_state = 6'd5;
    acc = 0;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge i_clk);
      if (o_req_ready) acc = 1;
    end
    @(posedge i_clk); #1 i_req_valid = 1'b0;
    @(posedge i_clk); #1 i_rst_n = 1'b0;
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 ||
        o_rsp_action !== 2'd0 || o_rsp_qmax !== 8'd0 ||
        o_mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: rdy=%b v=%b a=%0d q=%h rd=%b want 1 0 0 00 0",
               o_req_ready, o_rsp_valid, o_rsp_action, o_rsp_qmax,
               o_mem_rd_en);
    end
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      if (o_rsp_valid || o_mem_rd_en) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL midrst_noresp: stray=%0d want 0", stray);
    end
    do_query(6'd5, 32'd0, 0, 0, 6'd0, ok, lat, a, q, nrd, bv, us, rv);
    checks++;
    if (!ok || a !== 2'd1 || q !== 8'h30 || lat !== 6) begin
      errors++;
      $display("FAIL midrst_fresh: ok=%0d act=%0d q=%h lat=%0d want 1 1 30 6",
               ok, a, q, lat);
    end
  endtask

  task automatic test_random();
    bit ok; int lat, nrd, bv, us, rv;
    logic [1:0] a, ea; logic [7:0] q, eq;
    logic [5:0] s; logic [31:0] m; int rw;
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 1) != 0) ? 8'($urandom)
                                           : 8'($urandom_range(0, 3) * 64);
    for (int n = 0; n < 40; n++) begin
      s = 6'($urandom);
      m = 32'($urandom_range(0, 255) & $urandom_range(0, 255));
      rw = $urandom_range(0, 2);
      do_query(s, m, rw, 0, 6'd0, ok, lat, a, q, nrd, bv, us, rv);
      ref_argmax(s, ea, eq);
      checks++;
      if (!ok || a !== ea || q !== eq) begin
        errors++;
        $display("FAIL rand_result[%0d]: s=%0d ok=%0d act=%0d q=%h want %0d %h",
                 n, s, ok, a, q, ea, eq);
      end
      checks++;
      if (lat !== exp_lat(m) || nrd !== 4 || bv !== 0 || us !== 0) begin
        errors++;
        $display("FAIL rand_timing[%0d]: lat=%0d n=%0d bv=%0d us=%0d want %0d 4 0 0",
                 n, lat, nrd, bv, us, exp_lat(m));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_ties();
    test_busy();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
